contador_bcd_cascata: RTL



---
 rtl/contador_bcd_cascata.sv | 109 ++++++++++
 1 files changed

// File: rtl/contador_bcd_cascata.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// contador_bcd_cascata
// Multi-digit cascaded BCD counter with up/down counting, synchronous clear,
// sanitised parallel load and a registered one-cycle wrap pulse.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits (1..8)
//   TOP_MOD     modulus of the most significant digit (2..10)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset (valor = 0, carry = 0)
//   clear       synchronous clear, highest synchronous priority
//   load        synchronous parallel load of load_value (clamped per digit)
//   enable      step the counter one count this cycle
//   up_down     1 = count up, 0 = count down
//   load_value  BCD load data, digit i at [4i+3:4i]
//   valor       current BCD count, packed like load_value
//   carry       one-cycle pulse aligned with the wrapped value on valor
// -----------------------------------------------------------------------------
module contador_bcd_cascata #(
    parameter int NUM_DIGITS = 3,
    parameter int TOP_MOD    = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] valor,
    output logic                    carry
);

    // low_max[i]: every digit below i sits at its maximum (so digit i steps
    // when counting up). low_zero[i]: every digit below i is 0 (steps down).
    // Index NUM_DIGITS therefore flags the whole counter at MAX / at zero.
    logic [NUM_DIGITS:0] low_max;
    logic [NUM_DIGITS:0] low_zero;
    logic                wrap;
    logic                carry_reg;

    assign low_max[0]  = 1'b1;
    assign low_zero[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            // Only the top digit uses the reduced modulus.
            localparam logic [3:0] DMAX = (gi == NUM_DIGITS - 1) ? 4'(TOP_MOD - 1) : 4'd9;

            logic [3:0] d_reg;
            logic [3:0] d_next;
            logic [3:0] d_load;

            assign low_max[gi+1]  = low_max[gi]  & (d_reg == DMAX);
            assign low_zero[gi+1] = low_zero[gi] & (d_reg == 4'd0);

            // Clamp out-of-range load data so valor never holds an illegal digit.
            assign d_load = (load_value[4*gi +: 4] > DMAX) ? DMAX : load_value[4*gi +: 4];

            always_comb begin
                d_next = d_reg;
                if (up_down) begin
                    if (low_max[gi]) begin
                        d_next = (d_reg == DMAX) ? 4'd0 : d_reg + 4'd1;
                    end
                end else begin
                    if (low_zero[gi]) begin
                        d_next = (d_reg == 4'd0) ? DMAX : d_reg - 4'd1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    d_reg <= 4'd0;
                end else if (clear) begin
                    d_reg <= 4'd0;
                end else if (load) begin
                    d_reg <= d_load;
                end else if (enable) begin
                    d_reg <= d_next;
                end
            end

            assign valor[4*gi +: 4] = d_reg;
        end
    endgenerate

    // The counter wraps on this step when it is at MAX going up or at 0 going down.
    assign wrap = up_down ? low_max[NUM_DIGITS] : low_zero[NUM_DIGITS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_reg <= 1'b0;
        end else if (clear || load) begin
            carry_reg <= 1'b0;
        end else if (enable) begin
            carry_reg <= wrap;
        end else begin
            carry_reg <= 1'b0;
        end
    end

    assign carry = carry_reg;

endmodule
